// File: rtl/sync_fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and a sync_fifo.
//   req          producer request flags, one bit per producer
//   req_data     producer words, producer i on [i*DATA_WIDTH +: DATA_WIDTH]
//   ack          one-hot (or zero) acknowledge back to the producers
//   fifo_full    full flag from the sync_fifo
//   fifo_w_en    write enable to the sync_fifo
//   fifo_data    write data to the sync_fifo
//   fifo_src     index of the producer being written (0 when idle)
//   burst_active high while a producer holds a burst lock
// Modport master is the arbiter; slave is the producer/FIFO environment.
interface sync_fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [ID_WIDTH-1:0]           fifo_src;
    logic                          burst_active;

    modport master (
        input  req, req_data, fifo_full,
        output ack, fifo_w_en, fifo_data, fifo_src, burst_active
    );

    modport slave (
        output req, req_data, fifo_full,
        input  ack, fifo_w_en, fifo_data, fifo_src, burst_active
    );
endinterface

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync_fifo write port among NUM_REQ
// producers, with an optional burst lock of up to MAX_BURST words per grant.
//   clk  rising-edge clock
//   rst  synchronous active-high reset; forces all outputs to 0
//   bus  sync_fifo_wr_arbiter_if.master: producer req/data/ack, FIFO write
//        port (w_en/data/full), fifo_src and burst_active status
// Outputs are combinational from state, req and fifo_full (zero-latency write).
module sync_fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input logic                    clk,
    input logic                    rst,
    sync_fifo_wr_arbiter_if.master bus
);
    localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BURST - 1);

    logic [0:0]           fsm_q, fsm_d;
    logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]  owner_q, owner_d;
    logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;

    logic                cand_found;
    logic [ID_WIDTH-1:0] cand;
    logic [ID_WIDTH-1:0] scan_idx;
    logic                grant;
    logic [ID_WIDTH-1:0] sel;

    // Explicit wrap so non-power-of-2 NUM_REQ never indexes past the last producer.
    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_WIDTH'(1);
    endfunction

    // First requester at or after ptr, scanning modulo NUM_REQ.
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        scan_idx   = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!cand_found && bus.req[scan_idx]) begin
                cand_found = 1'b1;
                cand       = scan_idx;
            end
            scan_idx = next_id(scan_idx);
        end
    end

    always_comb begin
        grant       = 1'b0;
        sel         = '0;
        fsm_d       = fsm_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        case (fsm_q)
            IDLE: begin
                // A blocked candidate leaves ptr alone so it keeps its turn.
                if (cand_found && !bus.fifo_full) begin
                    grant = 1'b1;
                    sel   = cand;
                    if (MAX_BURST == 1) begin
                        ptr_d = next_id(cand);
                    end else begin
                        owner_d     = cand;
                        burst_cnt_d = CNT_WIDTH'(1);
                        fsm_d       = LOCK;
                    end
                end
            end
            LOCK: begin
                if (!bus.req[owner_q]) begin
                    // Owner gave up early: release with a one-cycle bubble.
                    ptr_d = next_id(owner_q);
                    fsm_d = IDLE;
                end else if (!bus.fifo_full) begin
                    grant = 1'b1;
                    sel   = owner_q;
                    if (burst_cnt_q == LAST_CNT) begin
                        ptr_d       = next_id(owner_q);
                        burst_cnt_d = '0;
                        fsm_d       = IDLE;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (rst) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        bus.ack       = '0;
        bus.fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (sel == ID_WIDTH'(i))) begin
                bus.ack[i]    = 1'b1;
                bus.fifo_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.fifo_w_en    = grant;
    assign bus.fifo_src     = grant ? sel : '0;
    assign bus.burst_active = !rst && (fsm_q == LOCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Bench for sync_fifo_wr_arbiter: one word-by-word (MAX_BURST=1) and one
// burst-lock (MAX_BURST=4) instance, each with its own producers and a
// depth-8 FIFO occupancy model driving fifo_full.
module tb_sync_fifo_wr_arbiter;
    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int IDW   = 2;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    sync_fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) if_rr ();
    sync_fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) if_bl ();

    sync_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (if_rr)
    );

    sync_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) u_bl (
        .clk (clk),
        .rst (rst),
        .bus (if_bl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int burst_len[2];
    bit pend[2][NR];
    logic [DW-1:0] word[2][NR];

    // Reference model: arbitration owner/turn held as plain integers.
    bit locked[2];
    int turn[2];
    int owner[2];
    int used[2];
    int fcount[2];

    int wq0[$];
    int wq1[$];
    bit bq0[$];
    bit bq1[$];

    int checks;
    int errors;

    bit mode_all;
    bit data_is_id;
    int read_pct;
    int req_pct;
    int drop_pct;

    task automatic chk(input bit ok, input int n, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL inst%0d %s: got %0d expected %0d at %0t", n, name, act, exp, $time);
        end
    endtask

    task automatic drive(input int n, input bit full);
        logic [NR-1:0] rq;
        logic [NR*DW-1:0] rdat;
        for (int i = 0; i < NR; i++) begin
            rq[i] = pend[n][i];
            rdat[i*DW +: DW] = word[n][i];
        end
        if (n == 0) begin
            if_rr.req = rq;
            if_rr.req_data = rdat;
            if_rr.fifo_full = full;
        end else begin
            if_bl.req = rq;
            if_bl.req_data = rdat;
            if_bl.fifo_full = full;
        end
    endtask

    task automatic do_cycle(input bit rst_v);
        bit full;
        bit w;
        bit rd;
        bit was_locked;
        int src;
        int c;
        @(posedge clk);
        #1;
        rst = rst_v;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (pend[n][i]) begin
                    if (!mode_all && ($urandom_range(99) < drop_pct)) pend[n][i] = 1'b0;
                end else if (mode_all || ($urandom_range(99) < req_pct)) begin
                    pend[n][i] = 1'b1;
                    word[n][i] = data_is_id ? DW'(i) : DW'($urandom);
                end
            end
            full = (fcount[n] >= DEPTH);
            drive(n, full);

            w = 1'b0;
            src = 0;
            was_locked = locked[n];
            if (rst_v) begin
                locked[n] = 1'b0;
                turn[n] = 0;
                owner[n] = 0;
                used[n] = 0;
            end else if (!locked[n]) begin
                c = -1;
                for (int k = 0; k < NR; k++) begin
                    if (c < 0 && pend[n][(turn[n] + k) % NR]) c = (turn[n] + k) % NR;
                end
                if (c >= 0 && !full) begin
                    w = 1'b1;
                    src = c;
                    if (burst_len[n] == 1) begin
                        turn[n] = (c + 1) % NR;
                    end else begin
                        owner[n] = c;
                        used[n] = 1;
                        locked[n] = 1'b1;
                    end
                end
            end else begin
                if (!pend[n][owner[n]]) begin
                    turn[n] = (owner[n] + 1) % NR;
                    locked[n] = 1'b0;
                end else if (!full) begin
                    w = 1'b1;
                    src = owner[n];
                    used[n]++;
                    if (used[n] == burst_len[n]) begin
                        turn[n] = (owner[n] + 1) % NR;
                        used[n] = 0;
                        locked[n] = 1'b0;
                    end
                end
            end

            if (n == 0) bq0.push_back(!rst_v && was_locked);
            else bq1.push_back(!rst_v && was_locked);
            if (w) begin
                if (n == 0) wq0.push_back(src * 256 + int'(word[n][src]));
                else wq1.push_back(src * 256 + int'(word[n][src]));
                pend[n][src] = 1'b0;
            end
            rd = ($urandom_range(99) < read_pct) && (fcount[n] > 0);
            fcount[n] = fcount[n] + int'(w) - int'(rd);
        end
    endtask

    task automatic mon(input int n, input logic w, input logic [NR-1:0] ack, input logic [DW-1:0] d,
                       input logic [IDW-1:0] s, input logic ba, input logic full);
        bit eb;
        int e;
        logic [NR-1:0] eack;
        eb = (n == 0) ? bq0.pop_front() : bq1.pop_front();
        chk(ba === eb, n, "burst_active", int'(ba), int'(eb));
        if (w === 1'b1) begin
            chk(full !== 1'b1, n, "w_en_while_full", int'(w), 0);
            if ((n == 0 && wq0.size() == 0) || (n == 1 && wq1.size() == 0)) begin
                chk(1'b0, n, "unexpected_write_src", int'(s), -1);
            end else begin
                e = (n == 0) ? wq0.pop_front() : wq1.pop_front();
                eack = '0;
                eack[e / 256] = 1'b1;
                chk(int'(s) == e / 256, n, "fifo_src", int'(s), e / 256);
                chk(int'(d) == e % 256, n, "fifo_data", int'(d), e % 256);
                chk(ack === eack, n, "ack", int'(ack), int'(eack));
            end
        end else begin
            chk(w === 1'b0 && ack === '0, n, "idle_ack", int'(ack), 0);
            chk(d === '0 && s === '0, n, "idle_data_src", int'(d) * 256 + int'(s), 0);
        end
    endtask

    always @(negedge clk) begin
        if (bq0.size() > 0) begin
            mon(0, if_rr.fifo_w_en, if_rr.ack, if_rr.fifo_data, if_rr.fifo_src,
                if_rr.burst_active, if_rr.fifo_full);
        end
        if (bq1.size() > 0) begin
            mon(1, if_bl.fifo_w_en, if_bl.ack, if_bl.fifo_data, if_bl.fifo_src,
                if_bl.burst_active, if_bl.fifo_full);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        burst_len[0] = 1;
        burst_len[1] = 4;
        for (int n = 0; n < 2; n++) begin
            locked[n] = 1'b0;
            turn[n] = 0;
            owner[n] = 0;
            used[n] = 0;
            fcount[n] = 0;
            for (int i = 0; i < NR; i++) begin
                pend[n][i] = 1'b0;
                word[n][i] = '0;
            end
            drive(n, 1'b0);
        end
        rst = 1'b1;

        // Reset held with all producers requesting, words equal to source id.
        mode_all = 1'b1;
        data_is_id = 1'b1;
        req_pct = 0;
        drop_pct = 0;
        read_pct = 100;
        repeat (3) do_cycle(1'b1);
        // Round-robin / back-to-back bursts with a draining FIFO.
        repeat (12) do_cycle(1'b0);
        // Fill with no reads, then trickle reads against a full FIFO.
        read_pct = 0;
        repeat (30) do_cycle(1'b0);
        read_pct = 30;
        repeat (30) do_cycle(1'b0);

        // Random traffic: sporadic requests, early drops, occasional reset.
        mode_all = 1'b0;
        data_is_id = 1'b0;
        req_pct = 40;
        drop_pct = 8;
        read_pct = 60;
        for (int c = 0; c < 2000; c++) do_cycle($urandom_range(199) == 0);

        // Reset landing on the second word of a burst.
        mode_all = 1'b1;
        read_pct = 100;
        do_cycle(1'b1);
        do_cycle(1'b0);
        do_cycle(1'b1);
        repeat (8) do_cycle(1'b0);

        @(negedge clk);
        #1;
        chk(wq0.size() == 0, 0, "writes_outstanding", wq0.size(), 0);
        chk(wq1.size() == 0, 1, "writes_outstanding", wq1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_wr_arbiter.md
Name: sync_fifo_wr_arbiter

Overview:
Round-robin write arbiter that lets NUM_REQ independent producers share the write port of a single sync_fifo instance. It drives the FIFO's write enable and data, and respects the FIFO's full flag. An optional burst lock keeps the grant on one producer for up to MAX_BURST consecutive words. It sits directly in front of sync_fifo; the read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (≥2)
DATA_WIDTH, 8, word width; must match the sync_fifo instance
MAX_BURST, 4, max consecutive words per grant (≥1); 1 = pure word-by-word round-robin
ID_WIDTH, $clog2(NUM_REQ), width of the source-id output

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  req[i]=1: producer i holds a valid word on its data slice
req_data  in  NUM_REQ*DATA_WIDTH  producer i word on bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  out  NUM_REQ  one-hot or zero; ack[i]=1: producer i's word is written this cycle
fifo_full  in  1  full flag from sync_fifo
fifo_w_en  out  1  write enable to sync_fifo
fifo_data  out  DATA_WIDTH  write data to sync_fifo
fifo_src  out  ID_WIDTH  index of the producer being written (0 when fifo_w_en=0)
burst_active  out  1  1 while in LOCK state

Behaviour:
- State: fsm {IDLE, LOCK}, ptr (ID_WIDTH bits, round-robin start index), owner (ID_WIDTH bits), burst_cnt (counts 0..MAX_BURST).
- Reset (rst=1 at a clock edge): fsm=IDLE, ptr=0, owner=0, burst_cnt=0.
- While rst=1, all outputs are forced to 0: ack, fifo_w_en, fifo_data, fifo_src, burst_active.
- rst asserted mid-burst aborts the burst. No write occurs in the reset cycle.
- Outputs are combinational from the current state, req and fifo_full; write latency is zero.
- fifo_w_en = |ack. Whenever fifo_w_en=0, fifo_data=0 and fifo_src=0.
- fifo_w_en is never asserted while fifo_full=1, so overflow is impossible by construction.
- Producer rule: req[i] and its data slice must stay stable until ack[i]. A producer may drop req[i] without an ack.
- IDLE:
  - cand = first i with req[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
  - No request: no write; state unchanged.
  - Candidate exists and fifo_full=1: no ack; ptr unchanged, so fairness is preserved.
  - Candidate exists and fifo_full=0: ack[cand]=1 and the word is written.
    - If MAX_BURST=1: ptr<=cand+1 mod NUM_REQ; stay in IDLE.
    - Otherwise: owner<=cand, burst_cnt<=1, fsm<=LOCK.
- LOCK (burst_active=1): only owner is considered; other requests are ignored.
  - req[owner]=0: release. ptr<=owner+1, fsm<=IDLE, no write this cycle (one-cycle bubble, by design).
  - req[owner]=1 and fifo_full=1: hold. No ack; owner, burst_cnt and fsm unchanged.
  - req[owner]=1 and fifo_full=0: write, then
    - if burst_cnt+1 == MAX_BURST: ptr<=owner+1, burst_cnt<=0, fsm<=IDLE;
    - else burst_cnt<=burst_cnt+1.
- ptr wrap-around: increment modulo NUM_REQ, e.g. 3+1=0 for NUM_REQ=4. For non-power-of-2 NUM_REQ, compare explicitly to NUM_REQ-1.
- Fairness bound: a continuously requesting producer is acked within (NUM_REQ-1)*(MAX_BURST+1)+1 non-full cycles.
- Simultaneous fifo_full deassert and new request: fifo_full is sampled combinationally, so the write happens in that same cycle.

Test Plan:
1. Reset/idle: rst=1 for 3 cycles with req=4'b1111 → ack=0, fifo_w_en=0, fifo_data=0, burst_active=0. After release, the first ack goes to producer 0.
2. Round-robin with MAX_BURST=1: req=4'b1111 held, FIFO never full, data = source id → ack sequence 0,1,2,3,0,1; fifo_src matches; scoreboard queue order matches the sync_fifo read order.
3. Burst lock with MAX_BURST=4: req=4'b0011 held → producer 0 written 4 consecutive cycles (burst_active=1 after the first), then producer 1 written 4 cycles, then producer 0 again; no bubble between bursts.
4. Early release: producer 2 alone drops req after 2 words in LOCK → one idle cycle with fifo_w_en=0, then ptr=3, and the next grant goes to 3 if requesting, else wraps to 0.
5. Full back-pressure: fill a depth-8 FIFO (no reads) with req=4'b1111 → exactly 8 writes. While full, ack=0 and state frozen. After one read deasserts fifo_full, the write resumes with the held owner/burst_cnt; no word is lost or duplicated.
6. Reset mid-burst: assert rst on the 2nd word of producer 1's burst → that cycle has no write. After release, fsm=IDLE and ptr=0, so producer 0 is granted first if requesting.
